mash_decimator: RTL and testbench

MASH_DECIMATOR -- requirements
Module: mash_decimator

---
 rtl/mash_pkg.sv | 14 +
 rtl/cic_comb.sv | 41 ++++
 rtl/mash_decimator.sv | 176 +++++++++++++++++
 tb/tb_mash_decimator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// Shared constants for the MASH modulator chain
// and its decimating CIC recovery filter.
package mash_pkg;

  localparam int DN_W       = 4;
  localparam int MASH_ORDER = 3;

  // CIC register width that holds R^3 growth
  // on a DN_W-bit input without overflow.
  function automatic int cic_width(input int bits);
    return DN_W + MASH_ORDER * bits;
  endfunction

endpackage

// File: rtl/cic_comb.sv
// One registered CIC differentiator, delay 1
// at the decimated rate.
module cic_comb #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] x_i,
  output logic         valid_o,
  output logic [W-1:0] y_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] y_q;
  logic         vld_q;

  // y = x - x_prev on each decimated sample, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      prev_q <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) begin
        prev_q <= x_i;
        y_q    <= x_i - prev_q;
      end
    end
  end

  assign valid_o = vld_q;
  assign y_o     = y_q;

endmodule

// File: rtl/mash_decimator.sv
// Third-order CIC decimator recovering the
// fractional word from a MASH output stream.
module mash_decimator
  import mash_pkg::*;
#(
  parameter  int BITS = 8,
  localparam int CW   = cic_width(BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic [3:0]      dn,
  input  logic            dn_valid,
  output logic [BITS-1:0] f_est,
  output logic            f_valid,
  output logic [CW-1:0]   cic_raw,
  output logic            settled
);

  localparam int SH = 2 * BITS;

  logic rst_meta_q;
  logic rst_sync_q;
  logic arst_n;

  // Async assert, clock-synchronised release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign arst_n = rst_sync_q;

  logic [CW-1:0]   dn_x;
  logic [CW-1:0]   i1_q;
  logic [CW-1:0]   i2_q;
  logic [CW-1:0]   i3_q;
  logic [CW-1:0]   i3_d;
  logic [BITS-1:0] cnt_q;
  logic            win_end;
  logic [CW-1:0]   snap_q;
  logic            snap_v_q;

  assign dn_x    = {{(CW-DN_W){dn[DN_W-1]}}, dn};
  assign i3_d    = i3_q + i2_q;
  assign win_end = dn_valid && (cnt_q == '1);

  // Integrators, window phase and snapshot
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      snap_v_q <= 1'b0;
    end else if (clr) begin
      i1_q     <= '0;
      i2_q     <= '0;
      i3_q     <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      snap_v_q <= 1'b0;
    end else begin
      snap_v_q <= win_end;
      if (dn_valid) begin
        i1_q  <= i1_q + dn_x;
        i2_q  <= i2_q + i1_q;
        i3_q  <= i3_d;
        cnt_q <= cnt_q + 1'b1;
      end
      if (win_end) begin
        snap_q <= i3_d;
      end
    end
  end

  logic          c1_v;
  logic          c2_v;
  logic          c3_v;
  logic [CW-1:0] c1_y;
  logic [CW-1:0] c2_y;
  logic [CW-1:0] c3_y;

  cic_comb #(.W(CW)) u_comb1 (
    .clk     (clk),
    .rst_n   (arst_n),
    .clr_i   (clr),
    .valid_i (snap_v_q),
    .x_i     (snap_q),
    .valid_o (c1_v),
    .y_o     (c1_y)
  );

  cic_comb #(.W(CW)) u_comb2 (
    .clk     (clk),
    .rst_n   (arst_n),
    .clr_i   (clr),
    .valid_i (c1_v),
    .x_i     (c1_y),
    .valid_o (c2_v),
    .y_o     (c2_y)
  );

  cic_comb #(.W(CW)) u_comb3 (
    .clk     (clk),
    .rst_n   (arst_n),
    .clr_i   (clr),
    .valid_i (c2_v),
    .x_i     (c2_y),
    .valid_o (c3_v),
    .y_o     (c3_y)
  );

  logic [CW:0]        half;
  logic [CW:0]        rnd_sum;
  logic signed [CW:0] rnd_shr;
  logic [BITS-1:0]    f_d;

  assign half    = (CW+1)'(1) << (SH - 1);
  assign rnd_sum = {c3_y[CW-1], c3_y} + half;
  assign rnd_shr = $signed(rnd_sum) >>> SH;

  // Round to nearest, clamp into 0..2^BITS-1
  always_comb begin
    f_d = rnd_shr[BITS-1:0];
    if (rnd_shr[CW]) begin
      f_d = '0;
    end else if (rnd_shr[CW-1:BITS] != '0) begin
      f_d = '1;
    end
  end

  logic [BITS-1:0] f_est_q;
  logic [CW-1:0]   cic_raw_q;
  logic            f_valid_q;
  logic            settled_q;
  logic [1:0]      nfv_q;

  // Output register; results survive clr
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      f_est_q   <= '0;
      cic_raw_q <= '0;
      f_valid_q <= 1'b0;
      settled_q <= 1'b0;
      nfv_q     <= '0;
    end else if (clr) begin
      f_valid_q <= 1'b0;
      settled_q <= 1'b0;
      nfv_q     <= '0;
    end else begin
      f_valid_q <= c3_v;
      if (c3_v) begin
        cic_raw_q <= c3_y;
        f_est_q   <= f_d;
        if (nfv_q == 2'd3) begin
          settled_q <= 1'b1;
        end else begin
          nfv_q <= nfv_q + 2'd1;
        end
      end
    end
  end

  assign f_est   = f_est_q;
  assign cic_raw = cic_raw_q;
  assign f_valid = f_valid_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_mash_decimator.sv
// Scoreboard bench for mash_decimator with a
// closed-form CIC reference and a MASH source.
module tb_mash_decimator;

  localparam int BITS = 8;
  localparam int CW   = 4 + 3 * BITS;
  localparam int R    = 1 << BITS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic [3:0]      dn = 4'd0;
  logic            dn_valid = 1'b0;
  logic [BITS-1:0] f_est;
  logic            f_valid;
  logic [CW-1:0]   cic_raw;
  logic            settled;

  mash_decimator #(.BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .dn       (dn),
    .dn_valid (dn_valid),
    .f_est    (f_est),
    .f_valid  (f_valid),
    .cic_raw  (cic_raw),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint          due;
    logic [CW-1:0]   cic;
    logic [BITS-1:0] fe;
    bit              chkf;
    int              f;
  } exp_t;

  exp_t   q[$];
  int     hist[$];
  longint sq[$];
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  logic   clr_s = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_s <= clr;
  end

  int a1 = 0, a2 = 0, a3 = 0;
  int c2p = 0, c3p = 0, c3pp = 0;

  // Third-order MASH 1-1-1 producing dn in -3..4
  function automatic int mash_step(input int f);
    int c1, c2, c3, y;
    a1 += f; c1 = a1 >> BITS; a1 &= R - 1;
    a2 += a1; c2 = a2 >> BITS; a2 &= R - 1;
    a3 += a2; c3 = a3 >> BITS; a3 &= R - 1;
    y = c1 + (c2 - c2p) + (c3 - 2 * c3p + c3pp);
    c2p = c2; c3pp = c3p; c3p = c3;
    return y;
  endfunction

  // Triple running sum at N=k*R samples:
  // sum x[n] * C(N-1-n, 2)
  function automatic longint s_at(input int k);
    longint acc, m;
    int n_tot;
    acc = 0;
    n_tot = k * R;
    for (int n = 0; n < n_tot; n++) begin
      m = longint'(n_tot - 1 - n);
      acc += longint'(hist[n]) * (m * (m - 1) / 2);
    end
    return acc;
  endfunction

  function automatic longint s_get(input int k);
    if (k <= 0) return 0;
    return sq[k-1];
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model(input bit v, input int d,
                       input bit c, input bit ism, input int f);
    exp_t   e;
    longint y, r;
    int     k;
    if (c) begin
      hist.delete();
      sq.delete();
      while (q.size() > 0 && q[q.size()-1].due > cyc)
        q.delete(q.size() - 1);
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() % R == 0) begin
        k = hist.size() / R;
        sq.push_back(s_at(k));
        y = s_get(k) - 3 * s_get(k-1)
            + 3 * s_get(k-2) - s_get(k-3);
        r = (y + (longint'(1) << (2*BITS-1))) >>> (2*BITS);
        if (r < 0) r = 0;
        if (r > R - 1) r = R - 1;
        e.due  = cyc + 5;
        e.cic  = y[CW-1:0];
        e.fe   = r[BITS-1:0];
        e.chkf = ism && (k >= 4);
        e.f    = f;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit v, input int d, input bit c,
                      input bit ism, input int f);
    @(posedge clk); #1;
    dn_valid = v;
    dn       = d[3:0];
    clr      = c;
    model(v, d, c, ism, f);
  endtask

  // mode 0: MASH(f), 1: constant dn=f, 2: random dn
  // gap 0: every cycle, 1: alternate, 2: random
  task automatic run(input int mode, input int f,
                     input int nsamp, input int gap);
    int  acc, i, d;
    bit  v;
    acc = 0;
    i = 0;
    while (acc < nsamp) begin
      if (gap == 0) v = 1'b1;
      else if (gap == 1) v = (i % 2 == 0);
      else v = ($urandom_range(0, 3) != 0);
      i++;
      if (v) begin
        if (mode == 0) d = mash_step(f);
        else if (mode == 1) d = f;
        else d = int'($urandom_range(0, 7)) - 3;
        acc++;
      end else begin
        d = int'($urandom_range(0, 15));
      end
      step(v, d, 1'b0, mode == 0, f);
    end
  endtask

  task automatic do_clr();
    step(1'b1, int'($urandom_range(0, 7)) - 3,
         1'b1, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_f_est"}, longint'(f_est), 0);
    chk({tag, "_cic_raw"}, longint'(cic_raw), 0);
    chk({tag, "_f_valid"}, longint'(f_valid), 0);
    chk({tag, "_settled"}, longint'(settled), 0);
  endtask

  logic [CW-1:0]   last_cic = '0;
  logic [BITS-1:0] last_fe = '0;
  int              n_fv = 0;

  // Monitor: pop and compare on each f_valid
  always @(negedge clk) begin
    exp_t e;
    int   fv;
    if (!rst_n) begin
      n_fv = 0;
      last_cic = '0;
      last_fe = '0;
    end else begin
      if (clr_s) n_fv = 0;
      if (f_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_f_valid cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("latency_cycle", cyc, e.due);
          chk("cic_raw", longint'($signed(cic_raw)),
              longint'($signed(e.cic)));
          chk("f_est", longint'(f_est), longint'(e.fe));
          if (e.chkf) begin
            fv = int'(f_est);
            checks++;
            if (fv < e.f - 1 || fv > e.f + 1) begin
              failures++;
              $display("FAIL f_est_window got=%0d f=%0d",
                       fv, e.f);
            end
          end
        end
        n_fv++;
      end else begin
        checks++;
        if (cic_raw !== last_cic || f_est !== last_fe) begin
          failures++;
          $display("FAIL hold got=%0d/%0d exp=%0d/%0d",
                   cic_raw, f_est, last_cic, last_fe);
        end
      end
      chk("settled", longint'(settled),
          longint'(n_fv >= 4));
      last_cic = cic_raw;
      last_fe  = f_est;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(4);

    run(0, 0, 6 * R, 0);
    do_clr();
    run(0, 77, 6 * R, 0);
    do_clr();
    run(0, 77, 6 * R, 1);
    do_clr();
    run(0, 77, 5 * R + 100, 0);
    do_clr();
    run(0, 77, 6 * R, 0);
    do_clr();
    run(1, 1, 5 * R, 0);
    do_clr();
    run(1, -3, 5 * R, 0);
    do_clr();
    run(0, int'($urandom_range(0, R - 1)), 6 * R, 2);
    do_clr();
    run(2, 0, 5 * R, 2);
    do_clr();
    run(0, 200, 2 * R, 0);

    idle(2);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    dn_valid = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    hist.delete();
    sq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    run(0, 200, 5 * R, 0);

    idle(10);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
